hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It computes EX-stage operand forwarding selects and detects load-use and control hazards. It sequences stalls through multi-cycle data-memory accesses with a timeout, and keeps saturating stall/flush performance counters. Its outputs drive the stage enables of IF, ID, EX and MEM, the ID/EX flush input of the decode stage, and the EX forwarding muxes.

## Interface
- ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, performance counter width
- TIMEOUT_CYCLES, 16, max consecutive wait cycles before memory error (≥2)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_rs1_addr_d, i_rs2_addr_d  in  ADDR_WIDTH  source regs of instruction in ID
- i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e  in  ADDR_WIDTH  regs of instruction in EX
- i_resultsrc_e0  in  1  EX instruction is a load (resultsrc[0])
- i_pcsrc_e  in  1  taken branch/jump resolved in EX
- i_regwrite_m, i_rd_addr_m  in  1/ADDR_WIDTH  MEM-stage writeback info
- i_regwrite_w, i_rd_addr_w  in  1/ADDR_WIDTH  WB-stage writeback info
- i_mem_req_m  in  1  MEM stage holds a load/store
- i_mem_ready  in  1  data memory completes access this cycle
- i_cnt_clr, i_err_clr  in  1  synchronous clear of counters / error flag
- o_stall_f, o_stall_d, o_stall_e, o_stall_m  out  1  hold stage register
- o_flush_d, o_flush_e, o_flush_w  out  1  bubble into IF/ID, ID/EX, MEM/WB
- o_forward_a_e, o_forward_b_e  out  2  00 regfile, 10 from MEM, 01 from WB
- o_mem_err  out  1  sticky memory timeout flag
- o_stall_cnt, o_flush_cnt  out  CNT_WIDTH  performance counters

## Operation
- Forwarding (combinational), per operand X in {a,b} using i_rsX_addr_e:
  - If rs≠0, i_regwrite_m is high and rs==rd_m → 10.
  - Else if rs≠0, i_regwrite_w is high and rs==rd_w → 01.
  - Else 00. MEM has priority over WB.
- lw_stall = i_resultsrc_e0 & i_rd_addr_e≠0 & (i_rd_addr_e==i_rs1_addr_d | i_rd_addr_e==i_rs2_addr_d).
- mem_stall = (state==RUN & i_mem_req_m & !i_mem_ready & !timeout) | (state==WAIT & !i_mem_ready & !timeout).
- FSM states and transitions:
  - RUN: if i_mem_req_m & !i_mem_ready → WAIT, wait counter = 1.
  - WAIT: if i_mem_ready → RUN. Else if wait counter == TIMEOUT_CYCLES-1 → timeout this cycle: mem_stall deasserts, o_mem_err set, → RUN. Otherwise wait counter increments.
- Output priority:
  - If mem_stall: o_stall_f/d/e/m=1, o_flush_w=1, o_flush_d=o_flush_e=0. lw_stall and pcsrc are ignored; they re-evaluate once the pipeline is released.
  - Else: o_stall_f=o_stall_d=lw_stall; o_flush_e=lw_stall|i_pcsrc_e; o_flush_d=i_pcsrc_e; o_stall_e/m=0; o_flush_w=0.
  - lw_stall and i_pcsrc_e are mutually exclusive, since EX holds one instruction. If both are presented, pcsrc flushes win and o_stall_f is still driven by lw_stall.
- Counters:
  - o_stall_cnt increments each cycle o_stall_d=1.
  - o_flush_cnt increments each cycle o_flush_d=1.
  - Both saturate at all-ones.
  - i_cnt_clr zeroes both; it has priority over increment.
- o_mem_err: set on timeout, cleared by i_err_clr. If set and clear coincide, set wins.

## Timing
- Reset: state=RUN, wait counter=0, o_mem_err=0, counters=0.
- All stall, flush and forward outputs are combinational from inputs and state, with zero latency. With reset held and inputs at 0, every stall, flush and forward output is 0.
- Reset is asynchronous and may occur mid-WAIT: the FSM returns to RUN immediately and the outputs drop.
- Memory ready in the same cycle as the request: no stall.
- Memory ready after N wait cycles: stall holds for exactly N cycles.
- Counter, error flag and FSM updates take effect on the next rising edge.

## Test plan
- Forwarding: EX rs1=5. MEM rd=5 with regwrite → fwd_a=10. Same case with WB also rd=5 → still 10. rs1=0 with MEM rd=0 → 00.
- Load-use: EX load rd=7, ID rs2=7 → stall_f=stall_d=flush_e=1 for one cycle; stall_cnt=1.
- Branch: i_pcsrc_e=1 → flush_d=flush_e=1, stall_f=0; flush_cnt increments by 1.
- Memory wait: req with ready low for 3 cycles → stall_f/d/e/m and flush_w high exactly 3 cycles; a pcsrc raised during the wait produces no flush until release.
- Timeout: TIMEOUT_CYCLES=16, ready never rises → stall deasserts in the 16th cycle and o_mem_err=1; i_err_clr clears it.
- Saturation/reset: preload by forcing CNT_WIDTH=4 with 20 stall cycles → o_stall_cnt=15. Asserting i_rst_n low mid-WAIT → stalls drop at once.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use/branch hazards,
// multi-cycle data-memory stall sequencing with timeout, and stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [ADDR_WIDTH-1:0] i_rs1_addr_d,
   input  logic [ADDR_WIDTH-1:0] i_rs2_addr_d,
   input  logic [ADDR_WIDTH-1:0] i_rs1_addr_e,
   input  logic [ADDR_WIDTH-1:0] i_rs2_addr_e,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
   input  logic                  i_resultsrc_e0,
   input  logic                  i_pcsrc_e,
   input  logic                  i_regwrite_m,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr_m,
   input  logic                  i_regwrite_w,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr_w,
   input  logic                  i_mem_req_m,
   input  logic                  i_mem_ready,
   input  logic                  i_cnt_clr,
   input  logic                  i_err_clr,
   output logic                  o_stall_f,
   output logic                  o_stall_d,
   output logic                  o_stall_e,
   output logic                  o_stall_m,
   output logic                  o_flush_d,
   output logic                  o_flush_e,
   output logic                  o_flush_w,
   output logic [1:0]            o_forward_a_e,
   output logic [1:0]            o_forward_b_e,
   output logic                  o_mem_err,
   output logic [CNT_WIDTH-1:0]  o_stall_cnt,
   output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

   localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t         state;
   logic [WCW-1:0] wait_cnt;
   logic           timeout;
   logic           mem_stall;
   logic           lw_stall;

   function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != '0 && i_regwrite_m && rs == i_rd_addr_m)
         sel = 2'b10;
      else if (rs != '0 && i_regwrite_w && rs == i_rd_addr_w)
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      o_forward_a_e = fwd_sel(i_rs1_addr_e);
      o_forward_b_e = fwd_sel(i_rs2_addr_e);
   end

   always_comb begin
      lw_stall  = i_resultsrc_e0 && (i_rd_addr_e != '0) &&
                  ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));
      timeout   = (state == ST_WAIT) && !i_mem_ready && (wait_cnt == WAIT_LAST);
      mem_stall = ((state == ST_RUN)  && i_mem_req_m && !i_mem_ready) ||
                  ((state == ST_WAIT) && !i_mem_ready && !timeout);
   end

   // A memory stall freezes the whole front of the pipe and hides lw/branch hazards
   // until release, when they are re-evaluated against the same held instructions.
   always_comb begin
      o_stall_f = 1'b0;
      o_stall_d = 1'b0;
      o_stall_e = 1'b0;
      o_stall_m = 1'b0;
      o_flush_d = 1'b0;
      o_flush_e = 1'b0;
      o_flush_w = 1'b0;
      if (mem_stall) begin
         o_stall_f = 1'b1;
         o_stall_d = 1'b1;
         o_stall_e = 1'b1;
         o_stall_m = 1'b1;
         o_flush_w = 1'b1;
      end else begin
         o_stall_f = lw_stall;
         o_stall_d = lw_stall;
         o_flush_e = lw_stall | i_pcsrc_e;
         o_flush_d = i_pcsrc_e;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (i_mem_req_m && !i_mem_ready) begin
                  state    <= ST_WAIT;
                  wait_cnt <= WCW'(1);
               end
            end
            ST_WAIT: begin
               if (i_mem_ready || timeout) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: begin
               state    <= ST_RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_mem_err <= 1'b0;
      else if (timeout)
         o_mem_err <= 1'b1;
      else if (i_err_clr)
         o_mem_err <= 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else if (i_cnt_clr) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_stall_d && o_stall_cnt != '1)
            o_stall_cnt <= o_stall_cnt + CNT_WIDTH'(1);
         if (o_flush_d && o_flush_cnt != '1)
            o_flush_cnt <= o_flush_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
